hex_display_arbiter: RTL and testbench

Fabric-side controller that owns the six HEX seven-segment displays and shares their single digit-register write port between two requesters. Requester A is the HPS, through an Avalon-MM slave on the lightweight bridge. Requester B is a fabric client using a req/gnt handshake. A round-robin state machine serializes writes. The block holds the digit bank, applies lock/blank control, and drives registered active-low segment outputs onto the board HEX pins.

---
 rtl/hex_display_arbiter.sv | 169 ++++++++++++++++
 tb/tb_hex_display_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_arbiter.sv
// Owns six HEX displays; round-robin arbitrates HPS (Avalon-MM) and fabric (req/gnt) writes into one digit bank.
// Each grant takes 2 cycles; HPS is stalled via avs_waitrequest, fabric waits for fab_gnt. Segments are registered.
module hex_display_arbiter #(
  parameter int NUM_DIGITS = 6
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [2:0] avs_address,
  input  logic       avs_write,
  input  logic [7:0] avs_writedata,
  input  logic       avs_read,
  output logic [7:0] avs_readdata,
  output logic       avs_waitrequest,
  input  logic       fab_req,
  input  logic [2:0] fab_digit,
  input  logic [7:0] fab_value,
  output logic       fab_gnt,
  output logic       fab_drop,
  output logic [6:0] hex0_conduit,
  output logic [6:0] hex1_conduit,
  output logic [6:0] hex2_conduit,
  output logic [6:0] hex3_conduit,
  output logic [6:0] hex4_conduit,
  output logic [6:0] hex5_conduit
);

  typedef enum logic [1:0] {IDLE, GNT_HPS, GNT_FAB} state_t;

  state_t     state, state_nxt;
  logic       ptr, ptr_nxt;            // 0: HPS has priority, 1: fabric
  logic [2:0] lat_addr, lat_addr_nxt;
  logic [7:0] lat_data, lat_data_nxt;

  logic [7:0] digit [NUM_DIGITS];
  logic [6:0] hex_q [NUM_DIGITS];
  logic       lock, blank;
  logic [6:0] drop_cnt;
  logic       last_writer;
  logic       hps_commit;
  logic [7:0] rd_mux;

  function automatic logic [6:0] seg_decode(input logic [7:0] d);
    logic [6:0] g;
    if (d[7]) begin
      g = ~d[6:0];
    end else begin
      case (d[3:0])
        4'h0: g = 7'h40;
        4'h1: g = 7'h79;
        4'h2: g = 7'h24;
        4'h3: g = 7'h30;
        4'h4: g = 7'h19;
        4'h5: g = 7'h12;
        4'h6: g = 7'h02;
        4'h7: g = 7'h78;
        4'h8: g = 7'h00;
        4'h9: g = 7'h10;
        4'hA: g = 7'h08;
        4'hB: g = 7'h03;
        4'hC: g = 7'h46;
        4'hD: g = 7'h21;
        4'hE: g = 7'h06;
        default: g = 7'h0E;
      endcase
    end
    return g;
  endfunction

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      lat_addr <= 3'd0;
      lat_data <= 8'h00;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      lat_addr <= lat_addr_nxt;
      lat_data <= lat_data_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    lat_addr_nxt = lat_addr;
    lat_data_nxt = lat_data;
    case (state)
      IDLE: begin
        // HPS wins when alone, or when both request and the pointer favours it
        if (avs_write && (!fab_req || !ptr)) begin
          state_nxt    = GNT_HPS;
          lat_addr_nxt = avs_address;
          lat_data_nxt = avs_writedata;
        end else if (fab_req) begin
          state_nxt    = GNT_FAB;
          lat_addr_nxt = fab_digit;
          lat_data_nxt = fab_value;
        end
      end
      GNT_HPS: begin
        ptr_nxt   = 1'b1;
        state_nxt = IDLE;
      end
      GNT_FAB: begin
        ptr_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign avs_waitrequest = avs_write & (state != GNT_HPS);
  assign fab_gnt         = (state == GNT_FAB);
  assign fab_drop        = fab_gnt & (lock | (lat_addr > 3'd5));
  assign hps_commit      = (state == GNT_HPS);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit[i] <= 8'h80;
      lock        <= 1'b0;
      blank       <= 1'b0;
      drop_cnt    <= 7'd0;
      last_writer <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (((hps_commit) || (fab_gnt && !fab_drop)) && lat_addr == 3'(i))
          digit[i] <= lat_data;
      end
      if (hps_commit && lat_addr == 3'd6) begin
        lock  <= lat_data[0];
        blank <= lat_data[1];
      end
      if (hps_commit && lat_addr != 3'd7) last_writer <= 1'b0;
      if (fab_gnt && !fab_drop) last_writer <= 1'b1;
      // Clear and increment come from different grant states, never the same cycle
      if (hps_commit && lat_addr == 3'd7) drop_cnt <= 7'd0;
      else if (fab_drop && drop_cnt != 7'h7F) drop_cnt <= drop_cnt + 7'd1;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (avs_address)
      3'd6:    rd_mux = {6'd0, blank, lock};
      3'd7:    rd_mux = {last_writer, drop_cnt};
      default: rd_mux = digit[avs_address];
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata <= 8'h00;
      for (int i = 0; i < NUM_DIGITS; i++) hex_q[i] <= 7'h7F;
    end else begin
      if (avs_read && !avs_write) avs_readdata <= rd_mux;
      for (int i = 0; i < NUM_DIGITS; i++)
        hex_q[i] <= blank ? 7'h7F : seg_decode(digit[i]);
    end
  end

  assign hex0_conduit = hex_q[0];
  assign hex1_conduit = hex_q[1];
  assign hex2_conduit = hex_q[2];
  assign hex3_conduit = hex_q[3];
  assign hex4_conduit = hex_q[4];
  assign hex5_conduit = hex_q[5];

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter: table of HPS digit writes plus hand-timed arbitration, drop, blank and reset sequences.
module tb_hex_display_arbiter;
  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic [2:0] avs_address;
  logic       avs_write;
  logic [7:0] avs_writedata;
  logic       avs_read;
  logic [7:0] avs_readdata;
  logic       avs_waitrequest;
  logic       fab_req;
  logic [2:0] fab_digit;
  logic [7:0] fab_value;
  logic       fab_gnt;
  logic       fab_drop;
  logic [6:0] hex0_conduit, hex1_conduit, hex2_conduit;
  logic [6:0] hex3_conduit, hex4_conduit, hex5_conduit;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    logic [6:0] glyph;
  } vec_t;

  vec_t       tbl [9];
  logic [6:0] exp_glyph [6];

  hex_display_arbiter dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_read(avs_read), .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .fab_req(fab_req), .fab_digit(fab_digit), .fab_value(fab_value),
    .fab_gnt(fab_gnt), .fab_drop(fab_drop),
    .hex0_conduit(hex0_conduit), .hex1_conduit(hex1_conduit), .hex2_conduit(hex2_conduit),
    .hex3_conduit(hex3_conduit), .hex4_conduit(hex4_conduit), .hex5_conduit(hex5_conduit)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] hex_of(input int idx);
    case (idx)
      0: return hex0_conduit;
      1: return hex1_conduit;
      2: return hex2_conduit;
      3: return hex3_conduit;
      4: return hex4_conduit;
      default: return hex5_conduit;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h, want %02h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic hps_write(input logic [2:0] a, input logic [7:0] d);
    int n = 0;
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk_clk);
    while (avs_waitrequest && n < 20) begin
      @(negedge clk_clk);
      n++;
    end
    if (n >= 20) begin
      tests++; fails++;
      $display("FAIL hps_write_timeout: waitrequest stuck high, addr %0d", a);
    end
    @(posedge clk_clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic hps_read(input logic [2:0] a, output logic [7:0] d);
    avs_address = a; avs_read = 1'b1;
    @(posedge clk_clk); #1;
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic fab_write(input logic [2:0] dg, input logic [7:0] v, output logic drop_seen);
    int n = 0;
    fab_digit = dg; fab_value = v; fab_req = 1'b1;
    @(negedge clk_clk);
    while (!fab_gnt && n < 20) begin
      @(negedge clk_clk);
      n++;
    end
    if (n >= 20) begin
      tests++; fails++;
      $display("FAIL fab_write_timeout: no fab_gnt, digit %0d", dg);
    end
    drop_seen = fab_drop;
    @(posedge clk_clk); #1;
    fab_req = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    logic       dr;

    tbl[0] = '{3'd0, 8'h00, 7'h40};
    tbl[1] = '{3'd1, 8'h01, 7'h79};
    tbl[2] = '{3'd2, 8'h02, 7'h24};
    tbl[3] = '{3'd3, 8'h08, 7'h00};
    tbl[4] = '{3'd4, 8'h0F, 7'h0E};
    tbl[5] = '{3'd5, 8'h8F, 7'h70};
    tbl[6] = '{3'd2, 8'h0A, 7'h08};
    tbl[7] = '{3'd1, 8'hF3, 7'h0C};
    tbl[8] = '{3'd3, 8'h7C, 7'h46};

    reset_reset_n = 1'b0;
    avs_address = 3'd0; avs_write = 1'b0; avs_writedata = 8'h00; avs_read = 1'b0;
    fab_req = 1'b0; fab_digit = 3'd0; fab_value = 8'h00;
    step(3);
    reset_reset_n = 1'b1;
    step(1);

    // Reset state
    check("rst_fab_gnt", {7'd0, fab_gnt}, 8'h00);
    check("rst_waitreq", {7'd0, avs_waitrequest}, 8'h00);
    check("rst_readdata", avs_readdata, 8'h00);
    for (int i = 0; i < 6; i++) check($sformatf("rst_hex%0d", i), {1'b0, hex_of(i)}, 8'h7F);
    for (int a = 0; a < 8; a++) begin
      hps_read(3'(a), rd);
      check($sformatf("rst_read_addr%0d", a), rd, (a < 6) ? 8'h80 : 8'h00);
    end

    // Uncontended HPS write, cycle-accurate
    avs_address = 3'd2; avs_writedata = 8'h05; avs_write = 1'b1;
    @(negedge clk_clk); check("hw_wr_cyc0", {7'd0, avs_waitrequest}, 8'h01);
    step(1);
    @(negedge clk_clk); check("hw_wr_cyc1", {7'd0, avs_waitrequest}, 8'h00);
    step(1); avs_write = 1'b0;
    @(negedge clk_clk); check("hw_hex2_cyc2", {1'b0, hex2_conduit}, 8'h7F);
    step(1);
    @(negedge clk_clk); check("hw_hex2_cyc3", {1'b0, hex2_conduit}, 8'h12);
    step(1);
    hps_read(3'd7, rd); check("hw_status", rd, 8'h00);

    // Table of HPS digit writes
    for (int i = 0; i < 9; i++) begin
      hps_write(tbl[i].addr, tbl[i].data);
      step(1);
      check($sformatf("tbl%0d_hex", i), {1'b0, hex_of(int'(tbl[i].addr))}, {1'b0, tbl[i].glyph});
      hps_read(tbl[i].addr, rd);
      check($sformatf("tbl%0d_read", i), rd, tbl[i].data);
      exp_glyph[tbl[i].addr] = tbl[i].glyph;
    end

    // Lone fabric write, cycle-accurate; leaves the pointer at HPS
    fab_digit = 3'd4; fab_value = 8'h09; fab_req = 1'b1;
    @(negedge clk_clk); check("fw_gnt_cyc0", {7'd0, fab_gnt}, 8'h00);
    step(1);
    @(negedge clk_clk);
    check("fw_gnt_cyc1", {7'd0, fab_gnt}, 8'h01);
    check("fw_drop_cyc1", {7'd0, fab_drop}, 8'h00);
    step(1); fab_req = 1'b0;
    @(negedge clk_clk); check("fw_gnt_cyc2", {7'd0, fab_gnt}, 8'h00);
    step(1);
    check("fw_hex4", {1'b0, hex4_conduit}, 8'h10);
    exp_glyph[4] = 7'h10;

    // Collision with pointer at HPS
    avs_address = 3'd0; avs_writedata = 8'h01; avs_write = 1'b1;
    fab_digit = 3'd0; fab_value = 8'h8F; fab_req = 1'b1;
    @(negedge clk_clk);
    check("c1_wr_cyc0", {7'd0, avs_waitrequest}, 8'h01);
    check("c1_gnt_cyc0", {7'd0, fab_gnt}, 8'h00);
    step(1);
    @(negedge clk_clk);
    check("c1_wr_cyc1", {7'd0, avs_waitrequest}, 8'h00);
    check("c1_gnt_cyc1", {7'd0, fab_gnt}, 8'h00);
    step(1); avs_write = 1'b0;
    @(negedge clk_clk); check("c1_gnt_cyc2", {7'd0, fab_gnt}, 8'h00);
    step(1);
    @(negedge clk_clk); check("c1_gnt_cyc3", {7'd0, fab_gnt}, 8'h01);
    step(1); fab_req = 1'b0;
    step(1);
    check("c1_hex0", {1'b0, hex0_conduit}, 8'h70);
    hps_read(3'd7, rd); check("c1_status", rd, 8'h80);

    // An HPS grant moves the pointer to fabric, so the next collision goes fabric-first
    hps_write(3'd5, 8'h06);
    exp_glyph[5] = 7'h02;
    avs_address = 3'd0; avs_writedata = 8'h01; avs_write = 1'b1;
    fab_digit = 3'd0; fab_value = 8'h8F; fab_req = 1'b1;
    step(1);
    @(negedge clk_clk);
    check("c2_gnt_cyc1", {7'd0, fab_gnt}, 8'h01);
    check("c2_wr_cyc1", {7'd0, avs_waitrequest}, 8'h01);
    step(1); fab_req = 1'b0;
    @(negedge clk_clk); check("c2_wr_cyc2", {7'd0, avs_waitrequest}, 8'h01);
    step(1);
    @(negedge clk_clk); check("c2_wr_cyc3", {7'd0, avs_waitrequest}, 8'h00);
    step(1); avs_write = 1'b0;
    step(1);
    check("c2_hex0", {1'b0, hex0_conduit}, 8'h79);
    exp_glyph[0] = 7'h79;
    hps_read(3'd7, rd); check("c2_status", rd, 8'h00);

    // Lock and out-of-range drops, counter clear
    hps_write(3'd6, 8'h01);
    hps_read(3'd6, rd); check("lock_ctrl_read", rd, 8'h01);
    fab_write(3'd1, 8'h88, dr);
    check("lock_drop_pulse", {7'd0, dr}, 8'h01);
    hps_read(3'd1, rd); check("lock_digit1_kept", rd, 8'hF3);
    hps_read(3'd7, rd); check("lock_cnt1", rd, 8'h01);
    hps_write(3'd6, 8'h00);
    fab_write(3'd7, 8'h11, dr);
    check("range_drop_pulse", {7'd0, dr}, 8'h01);
    hps_read(3'd7, rd); check("range_cnt2", rd, 8'h02);
    hps_write(3'd7, 8'h55);
    hps_read(3'd7, rd); check("cnt_clear", rd, 8'h00);

    // Saturation
    for (int i = 0; i < 130; i++) fab_write(3'd6, 8'h00, dr);
    hps_read(3'd7, rd); check("cnt_saturate", rd, 8'h7F);

    // Blank and restore
    hps_write(3'd6, 8'h02);
    step(1);
    for (int i = 0; i < 6; i++) check($sformatf("blank_hex%0d", i), {1'b0, hex_of(i)}, 8'h7F);
    hps_read(3'd6, rd); check("blank_ctrl_read", rd, 8'h02);
    hps_write(3'd6, 8'h00);
    step(1);
    for (int i = 0; i < 6; i++)
      check($sformatf("unblank_hex%0d", i), {1'b0, hex_of(i)}, {1'b0, exp_glyph[i]});

    // Reset during GNT_FAB
    fab_digit = 3'd2; fab_value = 8'h8F; fab_req = 1'b1;
    step(1);
    @(negedge clk_clk);
    check("rstg_gnt_before", {7'd0, fab_gnt}, 8'h01);
    reset_reset_n = 1'b0;
    #1;
    check("rstg_gnt_after", {7'd0, fab_gnt}, 8'h00);
    for (int i = 0; i < 6; i++) check($sformatf("rstg_hex%0d", i), {1'b0, hex_of(i)}, 8'h7F);
    fab_req = 1'b0;
    step(2);
    reset_reset_n = 1'b1;
    step(1);
    hps_read(3'd2, rd); check("rstg_digit2", rd, 8'h80);
    step(1);
    check("rstg_hex2_settled", {1'b0, hex2_conduit}, 8'h7F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
